// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - two-requester WIDTH-bit adder built from one 4-bit ripple slice
// Operands shift right one nibble per RUN cycle while result nibbles shift in from the top.
module nibble_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             grant0;
  logic             grant1;
  logic [4:0]       slice;
  logic [WIDTH-1:0] sum_next;

  function automatic logic [4:0] nibble_add(input logic [3:0] x, input logic [3:0] y,
                                            input logic ci);
    logic [3:0] s;
    logic       c;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  assign grant0 = req0_valid & (!req1_valid | last_grant);
  assign grant1 = req1_valid & (!req0_valid | !last_grant);

  // Gated by rst_n so the readies are also 0 while reset is held.
  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign rsp_valid  = (state == DONE);

  assign slice    = nibble_add(a_reg[3:0], b_reg[3:0], carry);
  assign sum_next = (rsp_sum >> 4) | (WIDTH'(slice[3:0]) << (WIDTH - 4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      idx        <= '0;
      carry      <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            a_reg      <= req1_ready ? req1_a : req0_a;
            b_reg      <= req1_ready ? req1_b : req0_b;
            carry      <= req1_ready ? req1_cin : req0_cin;
            idx        <= '0;
            last_grant <= req1_ready;
            rsp_id     <= req1_ready;
            state      <= RUN;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> 4;
          b_reg   <= b_reg >> 4;
          rsp_sum <= sum_next;
          carry   <= slice[4];
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            rsp_cout <= slice[4];
            state    <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Shared-adder controller that arbitrates between two requesters and computes WIDTH-bit sums by sequencing a single internal 4-bit ripple-carry adder slice over WIDTH/4 cycles, one nibble per cycle, LSB first. It sits between two operand producers and one result consumer. It trades latency for area, so the wide add costs only one 4-bit adder plus registers. The internal slice is the team's standard full-adder chain: sum = a^b^cin, carry = (a&b) | (cin&(a^b)).

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4. N = WIDTH/4 nibble steps.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_cin  input  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- rsp_cout  output  1  carry out of the top nibble
- rsp_id  output  1  index of the requester that owns the result

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE grant rules:
  - grant0 = req0_valid & (!req1_valid | last_grant==1).
  - grant1 = req1_valid & (!req0_valid | last_grant==0).
  - reqX_ready = (state==IDLE) & grantX. This is combinational; at most one ready is high.
- Handshake (reqX_valid & reqX_ready):
  - Capture a, b and cin into internal registers, with carry <= cin.
  - Set idx <= 0, last_grant <= X, rsp_id <= X.
  - Go to RUN.
- RUN, once per cycle:
  - The slice adds a[4*idx+3:4*idx] + b[...] + carry.
  - The 4-bit result is written into result nibble idx, and carry <= slice carry-out.
  - idx increments.
  - On the cycle that processes idx==N-1, go to DONE.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are stable.
  - On rsp_ready, go to IDLE.
  - No request is accepted in DONE or RUN: both readies are 0.
- Requesters hold valid and operands stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- Overflow wraps modulo 2^WIDTH; the carry appears only on rsp_cout.
- rst_n low, async, at any time:
  - State goes to IDLE, last_grant to 1 (so req0 wins the first contention).
  - idx, carry, the operand registers, rsp_sum, rsp_cout and rsp_id go to 0; rsp_valid goes to 0.
  - Any in-flight operation is discarded with no response.

## Timing
- All outputs are 0 during reset. reqX_ready may rise combinationally in the first IDLE cycle after reset release.
- Request handshake at edge T. RUN occupies cycles T+1..T+N. rsp_valid is high from the cycle after T+N (N+1 cycles after the handshake) until the rsp_ready handshake.
- Back-to-back: after the rsp handshake at edge R, the FSM is in IDLE in cycle R+1 and can accept a request there. Minimum period is N+2 cycles per operation (6 for WIDTH=16).
- A rsp_ready held high on DONE entry completes in one cycle.
- Backpressure holds DONE indefinitely; all rsp outputs are stable.

## Test plan
- Single add, WIDTH=16: req0 a=0x1234, b=0x0FFF, cin=0 -> rsp_sum=0x2233, rsp_cout=0, rsp_id=0; rsp_valid asserted 5 cycles after the handshake.
- Inter-nibble carry chain: a=0x0F0F, b=0x0101, cin=1 -> rsp_sum=0x1011, rsp_cout=0. Also a=0xFFFF, b=0x0001, cin=0 -> 0x0000, cout=1; a=0xFFFF, b=0x0000, cin=1 -> 0x0000, cout=1.
- Contention: both valid continuously after reset with distinct operands -> grants alternate 0,1,0,1. rsp_id follows the same sequence and each sum matches its requester's operands.
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid/rsp_sum/rsp_cout/rsp_id held; req0_ready and req1_ready stay 0 throughout; after rsp_ready=1, the next grant comes in the following cycle.
- Reset mid-RUN: drop rst_n in the second RUN cycle -> all outputs 0 immediately and no response. After release, req1 alone with a=0x0001, b=0x0002, cin=0 -> sum 0x0003, id=1.
- Randomized: 1000 random operand/cin/valid/rsp_ready patterns -> every response equals the 17-bit reference add. There is no lost or duplicated operation, and ready is never high outside IDLE.
